// File: rtl/boot_loader.sv
// UART boot loader: takes a 16-bit little-endian word count, then packs data bytes into
// 32-bit words and writes them to data memory. Optional checksum byte via BOOT_CHECKSUM_EN.
module boot_loader #(
    parameter logic [14:0] BASE_ADDR = 15'h0000,
    parameter int          MAX_WORDS = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug,
    input  logic [7:0]  rxData,
    input  logic        rxValid,
    output logic [14:0] memAddr,
    output logic        memWrite,
    output logic [31:0] memDataIn,
    output logic [2:0]  memType,
    output logic        cpuHold,
    output logic        done,
    output logic        err
);

`ifdef BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_DONE} state_t;
`endif

    localparam logic [2:0] MEM_WORD = 3'b010;

    state_t      state_q, state_d;
    logic [7:0]  n_lo_q, n_lo_d;
    logic [15:0] n_q, n_d;
    logic [15:0] idx_q, idx_d;
    logic [1:0]  bc_q, bc_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        mem_write_q, mem_write_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_data_q, mem_data_d;
    logic [2:0]  mem_type_q, mem_type_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    logic [2:0]  lane_we;
    logic [23:0] lanes;
    logic [15:0] n_full;
    logic [14:0] word_addr;
    logic        last_word;

    // Bytes 0..2 of the word in flight; byte 3 is taken straight from rxData.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic [7:0] lane_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_q <= '0;
            end else if (lane_we[gi]) begin
                lane_q <= rxData;
            end
        end
        assign lanes[8*gi +: 8] = lane_q;
    end

    assign n_full    = {rxData, n_lo_q};
    assign word_addr = BASE_ADDR + {idx_q[12:0], 2'b00};
    assign last_word = (idx_q + 16'd1) == n_q;

    always_comb begin
        state_d     = state_q;
        n_lo_d      = n_lo_q;
        n_d         = n_q;
        idx_d       = idx_q;
        bc_d        = bc_q;
        done_d      = done_q;
        err_d       = err_q;
        lane_we     = '0;
        mem_write_d = 1'b0;
        mem_addr_d  = '0;
        mem_data_d  = '0;
        mem_type_d  = '0;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (debug) begin
                    state_d = S_LEN0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    n_lo_d  = '0;
                    n_d     = '0;
                    idx_d   = '0;
                    bc_d    = '0;
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            S_LEN0: begin
                if (!debug) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (rxValid) begin
                    n_lo_d  = rxData;
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (!debug) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (rxValid) begin
                    n_d = n_full;
                    if (n_full == 16'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b0;
                    end else if ({16'd0, n_full} > MAX_WORDS) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                        bc_d    = '0;
                    end
                end
            end
            S_DATA: begin
                if (!debug) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (rxValid) begin
`ifdef BOOT_CHECKSUM_EN
                    csum_d = csum_q ^ rxData;
`endif
                    if (bc_q != 2'd3) begin
                        lane_we = 3'b001 << bc_q;
                        bc_d    = bc_q + 2'd1;
                    end else begin
                        // Fourth byte: the write goes out next cycle while the
                        // next word's byte 0 can already be accepted.
                        bc_d        = '0;
                        mem_write_d = 1'b1;
                        mem_addr_d  = word_addr;
                        mem_data_d  = {rxData, lanes};
                        mem_type_d  = MEM_WORD;
                        idx_d       = idx_q + 16'd1;
                        if (last_word) begin
`ifdef BOOT_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
                            done_d  = 1'b1;
`endif
                        end
                    end
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (!debug) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (rxValid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    err_d   = (rxData != csum_q);
                end
            end
`endif
            S_DONE: begin
                if (!debug) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            n_lo_q      <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            bc_q        <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_type_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            n_lo_q      <= n_lo_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            bc_q        <= bc_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_type_q  <= mem_type_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign memWrite  = mem_write_q;
    assign memAddr   = mem_addr_q;
    assign memDataIn = mem_data_q;
    assign memType   = mem_type_q;
    assign cpuHold   = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule
